// File: rtl/avl_biu_1n_ordered.sv
// avl_biu_1n_ordered: 1-to-N Avalon-style bus interface unit with in-order
// read return. Requests are decoded against a prefix address map and forwarded
// with zero added latency; outstanding reads are tracked so that responses
// can only come from the slave currently owning the read stream.
// Optional build macro: AVL_BIU_DECERR_EN -- unmapped accesses go to an
// internal error pseudo-slave (reads return 0xDEADBEEF, dec_err pulses)
// instead of being routed to slave 0.

// Per-slave prefix comparator: hit when the top plen bits of addr equal base.
module avl_biu_1n_ordered_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [5:0]        plen,
  output logic              hit
);
  logic [ADDR_W-1:0] mask;

  // Mask covering the plen most significant bits; plen=0 matches everything.
  always_comb begin
    mask = '0;
    for (int b = 0; b < ADDR_W; b++)
      if (b >= ADDR_W - int'(plen)) mask[b] = 1'b1;
    hit = ((addr ^ base) & mask) == '0;
  end
endmodule

module avl_biu_1n_ordered #(
  parameter int SLAVE_NUM = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter logic [SLAVE_NUM*ADDR_W-1:0] MAP_BASE =
    {32'hE000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*6-1:0] MAP_PLEN = {6'd3, 6'd3, 6'd2, 6'd1}
) (
  input  logic                            clk,
  input  logic                            rest,
  input  logic [ADDR_W-1:0]               s_address,
  input  logic [DATA_W/8-1:0]             s_byteenable,
  input  logic                            s_read,
  input  logic                            s_write,
  input  logic [DATA_W-1:0]               s_writedata,
  output logic                            s_waitrequest,
  output logic [DATA_W-1:0]               s_readdata,
  output logic                            s_readdatavalid,
  output logic [SLAVE_NUM*ADDR_W-1:0]     m_address,
  output logic [SLAVE_NUM*DATA_W/8-1:0]   m_byteenable,
  output logic [SLAVE_NUM*DATA_W-1:0]     m_writedata,
  output logic [SLAVE_NUM-1:0]            m_read,
  output logic [SLAVE_NUM-1:0]            m_write,
  input  logic [SLAVE_NUM-1:0]            m_waitrequest,
  input  logic [SLAVE_NUM*DATA_W-1:0]     m_readdata,
  input  logic [SLAVE_NUM-1:0]            m_readdatavalid,
  output logic                            dec_err,
  output logic                            spur_rsp
);
  // Select ids run 0..SLAVE_NUM so the error pseudo-slave has its own code.
  localparam int SW = $clog2(SLAVE_NUM + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  logic [SLAVE_NUM-1:0] hit;
  logic [SW-1:0]        sel;
  logic                 stall;
  logic                 wait_sel;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 rsp_vld;
  logic [DATA_W-1:0]    rsp_data;
  logic [SLAVE_NUM-1:0] legal_rsp;

  logic [OW-1:0] outst_q, outst_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic          spur_q, spur_d;
`ifdef AVL_BIU_DECERR_EN
  localparam logic [SW-1:0] ERR_ID = SW'(SLAVE_NUM);
  logic sel_err;
  logic dec_pend_q, dec_pend_d;
`endif

  genvar g;
  generate
    for (g = 0; g < SLAVE_NUM; g++) begin : g_dec
      avl_biu_1n_ordered_match #(.ADDR_W(ADDR_W)) u_match (
        .addr (s_address),
        .base (MAP_BASE[g*ADDR_W +: ADDR_W]),
        .plen (MAP_PLEN[g*6 +: 6]),
        .hit  (hit[g])
      );
    end
  endgenerate

  // Request fields are broadcast; only the strobes are steered.
  assign m_address    = {SLAVE_NUM{s_address}};
  assign m_byteenable = {SLAVE_NUM{s_byteenable}};
  assign m_writedata  = {SLAVE_NUM{s_writedata}};

  // Decode (lowest index wins), ordering stall and strobe steering.
  always_comb begin
`ifdef AVL_BIU_DECERR_EN
    sel = ERR_ID;
`else
    sel = '0;
`endif
    for (int i = SLAVE_NUM - 1; i >= 0; i--)
      if (hit[i]) sel = SW'(i);
`ifdef AVL_BIU_DECERR_EN
    sel_err = (sel == ERR_ID);
`endif
    // Switching slaves is only safe once every read has returned; a full
    // counter blocks new reads even if a response lands this cycle.
    stall = ((outst_q != '0) && (sel != cur_sel_q)) ||
            (s_read && (outst_q == OUTST_MAX));
    wait_sel = 1'b0;
    m_read   = '0;
    m_write  = '0;
    for (int i = 0; i < SLAVE_NUM; i++)
      if (sel == SW'(i)) begin
        wait_sel   = m_waitrequest[i];
        m_read[i]  = s_read & ~stall;
        m_write[i] = s_write & ~stall;
      end
    s_waitrequest = stall | wait_sel;
    rd_acc = s_read & ~s_waitrequest;
    wr_acc = s_write & ~s_waitrequest;
  end

  // Response routing from the owning slave, spurious detection, next state.
  always_comb begin
    rsp_vld   = 1'b0;
    rsp_data  = '0;
    legal_rsp = '0;
    for (int i = 0; i < SLAVE_NUM; i++)
      if ((cur_sel_q == SW'(i)) && (outst_q != '0)) begin
        legal_rsp[i] = 1'b1;
        if (m_readdatavalid[i]) begin
          rsp_vld  = 1'b1;
          rsp_data = m_readdata[i*DATA_W +: DATA_W];
        end
      end
`ifdef AVL_BIU_DECERR_EN
    // Error reads always answer exactly one cycle after acceptance.
    if (dec_pend_q) begin
      rsp_vld  = 1'b1;
      rsp_data = {DATA_W/32{32'hDEAD_BEEF}};
    end
    dec_pend_d = rd_acc & sel_err;
    dec_err    = (rd_acc | wr_acc) & sel_err & ~rest;
`else
    dec_err = 1'b0;
`endif
    s_readdatavalid = rsp_vld;
    s_readdata      = rsp_data;
    spur_d = spur_q | (|(m_readdatavalid & ~legal_rsp));
    outst_d = outst_q;
    if (rd_acc && !rsp_vld)      outst_d = outst_q + 1'b1;
    else if (!rd_acc && rsp_vld) outst_d = outst_q - 1'b1;
    cur_sel_d = rd_acc ? sel : cur_sel_q;
  end

  assign spur_rsp = spur_q;

  // State registers.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      outst_q    <= '0;
      cur_sel_q  <= '0;
      spur_q     <= 1'b0;
`ifdef AVL_BIU_DECERR_EN
      dec_pend_q <= 1'b0;
`endif
    end else begin
      outst_q    <= outst_d;
      cur_sel_q  <= cur_sel_d;
      spur_q     <= spur_d;
`ifdef AVL_BIU_DECERR_EN
      dec_pend_q <= dec_pend_d;
`endif
    end
  end
endmodule

// File: tb/tb_avl_biu_1n_ordered.sv
// Bench for avl_biu_1n_ordered: decode table, hand-written ordering/reset
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_avl_biu_1n_ordered;
  localparam int SN = 4, AW = 32, DW = 32, BW = 4, MO = 2;

  logic clk = 1'b0;
  logic rest;
  always #5 clk = ~clk;

  logic [AW-1:0]    s_address;
  logic [BW-1:0]    s_byteenable;
  logic             s_read, s_write;
  logic [DW-1:0]    s_writedata;
  logic             s_waitrequest;
  logic [DW-1:0]    s_readdata;
  logic             s_readdatavalid;
  logic [SN*AW-1:0] m_address;
  logic [SN*BW-1:0] m_byteenable;
  logic [SN*DW-1:0] m_writedata;
  logic [SN-1:0]    m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [SN*DW-1:0] m_readdata;
  logic             dec_err, spur_rsp;

  avl_biu_1n_ordered u_dut (
    .clk(clk), .rest(rest), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .m_address(m_address),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_read(m_read),
    .m_write(m_write), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .dec_err(dec_err), .spur_rsp(spur_rsp));

  // Second instance: 2 slaves, only the lower half of the space reachable.
  logic [AW-1:0]  s_address2;
  logic [BW-1:0]  s_byteenable2;
  logic           s_read2, s_write2;
  logic [DW-1:0]  s_writedata2;
  logic           s_waitrequest2, s_readdatavalid2;
  logic [DW-1:0]  s_readdata2;
  logic [2*AW-1:0] m_address2;
  logic [2*BW-1:0] m_byteenable2;
  logic [2*DW-1:0] m_writedata2, m_readdata2;
  logic [1:0]     m_read2, m_write2, m_waitrequest2, m_readdatavalid2;
  logic           dec_err2, spur_rsp2;

  avl_biu_1n_ordered #(.SLAVE_NUM(2), .MAP_BASE({32'h4000_0000, 32'h0000_0000}),
                       .MAP_PLEN({6'd2, 6'd1})) u_dut2 (
    .clk(clk), .rest(rest), .s_address(s_address2), .s_byteenable(s_byteenable2),
    .s_read(s_read2), .s_write(s_write2), .s_writedata(s_writedata2),
    .s_waitrequest(s_waitrequest2), .s_readdata(s_readdata2),
    .s_readdatavalid(s_readdatavalid2), .m_address(m_address2),
    .m_byteenable(m_byteenable2), .m_writedata(m_writedata2), .m_read(m_read2),
    .m_write(m_write2), .m_waitrequest(m_waitrequest2), .m_readdata(m_readdata2),
    .m_readdatavalid(m_readdatavalid2), .dec_err(dec_err2), .spur_rsp(spur_rsp2));

  typedef struct { int due; logic [31:0] addr; } sreq_t;
  typedef struct { logic rd; logic wr; logic [31:0] addr; logic [3:0] mr; logic [3:0] mw; } vec_t;

  int n_chk, n_err, cyc, n_rv;
  int lat_min, lat_max, wait_mode;
  logic [SN-1:0] inj;
  logic mrd, mwr;
  logic [31:0] maddr, mwdata;
  logic [3:0] mbe;
  logic last_acc;
  logic [31:0] sb[$];
  int cur;
  bit exp_spur;
  sreq_t sq [SN][$];
  int last_due [SN];

  // Reference address map: plain range comparisons.
  function automatic int dec(input logic [31:0] a);
    if (a < 32'h8000_0000) return 0;
    if (a < 32'hC000_0000) return 1;
    if (a < 32'hE000_0000) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] sdata(input int i, input logic [31:0] a);
    return {a[27:0], 4'(i)} ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++; n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, update model at posedge.
  task automatic step();
    logic [SN-1:0] rdv, mw, mr_snap;
    int d, lat, due;
    bit ex_stall, ex_wait, ex_rv;
    logic [SN-1:0] ex_mr, ex_mw;
    sreq_t r;
    @(negedge clk);
    s_read = mrd; s_write = mwr; s_address = maddr; s_writedata = mwdata; s_byteenable = mbe;
    rdv = '0;
    m_readdata = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < SN; i++) begin
      if (sq[i].size() > 0 && sq[i][0].due <= cyc) begin
        rdv[i] = 1'b1;
        m_readdata[i*DW +: DW] = sdata(i, sq[i][0].addr);
      end
      case (wait_mode)
        0: mw[i] = 1'b0;
        1: mw[i] = ($urandom_range(3) == 0);
        default: mw[i] = 1'b1;
      endcase
    end
    m_readdatavalid = rdv | inj;
    m_waitrequest = mw;
    #1;
    d = dec(maddr);
    ex_stall = (sb.size() != 0 && d != cur) || (mrd && sb.size() == MO);
    ex_wait = ex_stall || mw[d];
    ex_mr = '0; ex_mw = '0;
    ex_mr[d] = mrd && !ex_stall;
    ex_mw[d] = mwr && !ex_stall;
    ex_rv = sb.size() > 0 && m_readdatavalid[cur];
    chk("waitrequest", s_waitrequest, ex_wait);
    chk("m_read", m_read, ex_mr);
    chk("m_write", m_write, ex_mw);
    chk("readdatavalid", s_readdatavalid, ex_rv);
    if (ex_rv) chk("readdata", s_readdata, sb[0]);
    chk("spur_rsp", spur_rsp, exp_spur);
    chk("dec_err", dec_err, 0);
    if (mrd || mwr)
      for (int i = 0; i < SN; i++) begin
        chk("m_address", m_address[i*AW +: AW], maddr);
        chk("m_writedata", m_writedata[i*DW +: DW], mwdata);
        chk("m_byteenable", m_byteenable[i*BW +: BW], mbe);
      end
    for (int j = 0; j < SN; j++)
      if (m_readdatavalid[j] && !(sb.size() > 0 && j == cur)) exp_spur = 1'b1;
    if (s_readdatavalid) n_rv++;
    last_acc = (mrd || mwr) && !s_waitrequest;
    mr_snap = m_read;
    @(posedge clk);
    if (ex_rv) void'(sb.pop_front());
    if (mrd && !ex_wait) begin sb.push_back(sdata(d, maddr)); cur = d; end
    for (int i = 0; i < SN; i++) begin
      if (rdv[i]) void'(sq[i].pop_front());
      if (mr_snap[i] && !mw[i]) begin
        lat = $urandom_range(lat_max, lat_min);
        due = (cyc + lat > last_due[i] + 1) ? cyc + lat : last_due[i] + 1;
        r.due = due; r.addr = maddr;
        sq[i].push_back(r);
        last_due[i] = due;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    mrd = 1'b0; mwr = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_req(input bit rd, input logic [31:0] a, output int waits);
    mrd = rd; mwr = !rd; maddr = a; mwdata = $urandom; mbe = 4'($urandom);
    waits = 0;
    forever begin
      step();
      if (last_acc) break;
      waits++;
      if (waits > 60) begin fail_now("req_timeout"); break; end
    end
    mrd = 1'b0; mwr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bit busy;
    forever begin
      busy = sb.size() != 0;
      for (int i = 0; i < SN; i++) if (sq[i].size() != 0) busy = 1'b1;
      if (!busy) break;
      idle(1);
      n++;
      if (n > 300) begin fail_now("drain_timeout"); break; end
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input bit keep_slaves);
    @(negedge clk); #2;
    rest = 1'b1;
    #1;
    chk("rst_readdatavalid", s_readdatavalid, 0);
    chk("rst_readdata", s_readdata, 0);
    chk("rst_spur_rsp", spur_rsp, 0);
    chk("rst_dec_err", dec_err, 0);
    mrd = 1'b0; mwr = 1'b0; s_read = 1'b0; s_write = 1'b0;
    m_readdatavalid = '0; inj = '0;
    #1;
    chk("rst_m_read", m_read, 0);
    sb.delete(); exp_spur = 1'b0;
    if (!keep_slaves) for (int i = 0; i < SN; i++) begin sq[i].delete(); last_due[i] = 0; end
    @(posedge clk); cyc++;
    @(negedge clk); rest = 1'b0;
    @(posedge clk); cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int w, tot, base;
    n_chk = 0; n_err = 0; cyc = 0; n_rv = 0; cur = 0; exp_spur = 1'b0;
    lat_min = 2; lat_max = 2; wait_mode = 0; inj = '0;
    mrd = 0; mwr = 0; maddr = '0; mwdata = '0; mbe = '0;
    for (int i = 0; i < SN; i++) last_due[i] = 0;
    rest = 1'b1;
    s_address = '0; s_byteenable = '0; s_read = 0; s_write = 0; s_writedata = '0;
    m_waitrequest = '0; m_readdata = '0; m_readdatavalid = '0;
    s_address2 = '0; s_byteenable2 = '0; s_read2 = 0; s_write2 = 0; s_writedata2 = '0;
    m_waitrequest2 = '0; m_readdata2 = '0; m_readdatavalid2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("init_readdatavalid", s_readdatavalid, 0);
    chk("init_readdata", s_readdata, 0);
    chk("init_spur_rsp", spur_rsp, 0);
    chk("init_dec_err", dec_err, 0);
    chk("init_m_read", m_read, 0);
    chk("init_m_write", m_write, 0);
    chk("init_waitrequest", s_waitrequest, 0);
    @(negedge clk); rest = 1'b0;
    @(posedge clk);

    // Decode table; all slaves stalled so nothing is accepted.
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 4'b0001, 4'b0000};
    tbl[1] = '{1'b1, 1'b0, 32'h8000_0004, 4'b0010, 4'b0000};
    tbl[2] = '{1'b1, 1'b0, 32'hC000_0000, 4'b0100, 4'b0000};
    tbl[3] = '{1'b1, 1'b0, 32'hE000_0000, 4'b1000, 4'b0000};
    tbl[4] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0001, 4'b0000};
    tbl[5] = '{1'b0, 1'b1, 32'hBFFF_FFFF, 4'b0000, 4'b0010};
    tbl[6] = '{1'b0, 1'b1, 32'hDFFF_FFFF, 4'b0000, 4'b0100};
    tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 4'b1000};
    tbl[8] = '{1'b0, 1'b1, 32'h0000_0000, 4'b0000, 4'b0001};
    tbl[9] = '{1'b0, 1'b0, 32'hC000_1234, 4'b0000, 4'b0000};
    wait_mode = 2;
    for (int k = 0; k < 10; k++) begin
      mrd = tbl[k].rd; mwr = tbl[k].wr; maddr = tbl[k].addr; mwdata = $urandom; mbe = 4'hF;
      step();
      chk("tbl_m_read", m_read, tbl[k].mr);
      chk("tbl_m_write", m_write, tbl[k].mw);
    end
    idle(1);
    wait_mode = 0;

    // T1: one read per slave, data returned per slave in order
    base = n_rv;
    do_req(1, 32'h0000_0010, w);
    do_req(1, 32'h8000_0004, w);
    do_req(1, 32'hC000_0000, w);
    do_req(1, 32'hE000_0000, w);
    drain();
    chk("T1_rsp_count", n_rv - base, 4);

    // T2: third read to slave 0 stalls while two are outstanding
    lat_min = 3; lat_max = 3;
    do_req(1, 32'h0000_0100, w); chk("T2_wait_a", w, 0);
    do_req(1, 32'h0000_0200, w); chk("T2_wait_b", w, 0);
    do_req(1, 32'h0000_0300, w); chk("T2_wait_c", w, 2);
    drain();

    // T3: read to slave 1 waits until slave 0 data has returned
    base = n_rv;
    do_req(1, 32'h0000_0040, w);
    do_req(1, 32'h8000_0040, w); chk("T3_wait_s1", w, 3);
    drain();
    chk("T3_rsp_count", n_rv - base, 2);

    // T4: response and new accept in the same cycle keep the count steady
    lat_min = 1; lat_max = 1; tot = 0; base = n_rv;
    for (int k = 0; k < 6; k++) begin
      do_req(1, 32'h0000_1000 + 32'(k*4), w);
      tot += w;
    end
    chk("T4_total_waits", tot, 0);
    drain();
    chk("T4_rsp_count", n_rv - base, 6);

    // T5: readdatavalid from slave 2 with nothing outstanding
    inj = 4'b0100; idle(1); inj = '0;
    idle(3);
    chk("T5_spur_sticky", spur_rsp, 1);
    do_reset(0);

    // T7: reset with two reads outstanding; late responses are spurious
    lat_min = 6; lat_max = 6;
    do_req(1, 32'h8000_0000, w);
    do_req(1, 32'h8000_0010, w);
    do_reset(1);
    idle(10);
    chk("T7_spur_after_reset", spur_rsp, 1);
    drain();
    do_reset(0);

    // Randomized traffic with random slave stalls and latencies
    wait_mode = 1; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(9) < 3) idle(1);
      else do_req($urandom_range(2) != 0, $urandom, w);
    end
    wait_mode = 0;
    drain();

    // T6: unmapped address on the 2-slave instance
    @(negedge clk);
    s_address2 = 32'h9000_0000; s_read2 = 1'b1; s_byteenable2 = 4'hF;
    #1;
`ifdef AVL_BIU_DECERR_EN
    chk("T6_m_read", m_read2, 2'b00);
    chk("T6_dec_err", dec_err2, 1);
    chk("T6_waitrequest", s_waitrequest2, 0);
    @(negedge clk); s_read2 = 1'b0; #1;
    chk("T6_readdatavalid", s_readdatavalid2, 1);
    chk("T6_readdata", s_readdata2, 32'hDEAD_BEEF);
    chk("T6_dec_err_off", dec_err2, 0);
`else
    chk("T6_m_read", m_read2, 2'b01);
    chk("T6_dec_err", dec_err2, 0);
    chk("T6_waitrequest", s_waitrequest2, 0);
    @(negedge clk); s_read2 = 1'b0; #1;
    chk("T6_readdatavalid", s_readdatavalid2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
